// File: rtl/framebuffer_scanout.sv
`default_nettype none
// framebuffer_scanout: raster timing generator and scaled framebuffer read path.
// Revision 1.0
module framebuffer_scanout #(
  parameter int   FRAME_WIDTH    = 640,
  parameter int   FRAME_HEIGHT   = 480,
  parameter int   H_FRONT        = 16,
  parameter int   H_SYNC         = 96,
  parameter int   H_BACK         = 48,
  parameter int   V_FRONT        = 10,
  parameter int   V_SYNC         = 2,
  parameter int   V_BACK         = 33,
  parameter logic SYNC_ACTIVE    = 1'b0,
  parameter int   SCALING_FACTOR = 1,
  parameter int   ADDR_WIDTH     = 19,
  parameter int   DATA_WIDTH     = 8,
  parameter int   RD_LATENCY     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_fb_rst_busy,
  output logic [ADDR_WIDTH-1:0] o_addr_rd,
  output logic                  o_en_rd,
  input  logic [DATA_WIDTH-1:0] i_fb_dout,
  output logic [DATA_WIDTH-1:0] o_pixel,
  output logic                  o_hsync,
  output logic                  o_vsync,
  output logic                  o_de,
  output logic                  o_frame_start
);

  localparam int c_H_TOTAL = FRAME_WIDTH + H_FRONT + H_SYNC + H_BACK;
  localparam int c_V_TOTAL = FRAME_HEIGHT + V_FRONT + V_SYNC + V_BACK;
  localparam int c_HW      = $clog2(c_H_TOTAL + 1);
  localparam int c_VW      = $clog2(c_V_TOTAL + 1);
  localparam int c_SW      = (SCALING_FACTOR > 1) ? $clog2(SCALING_FACTOR) : 1;
  localparam int c_D       = RD_LATENCY + 2;

  localparam logic [c_HW-1:0]       c_H_LAST     = c_HW'(c_H_TOTAL - 1);
  localparam logic [c_HW-1:0]       c_H_ACT      = c_HW'(FRAME_WIDTH);
  localparam logic [c_HW-1:0]       c_H_SYNC_BEG = c_HW'(FRAME_WIDTH + H_FRONT);
  localparam logic [c_HW-1:0]       c_H_SYNC_END = c_HW'(FRAME_WIDTH + H_FRONT + H_SYNC);
  localparam logic [c_VW-1:0]       c_V_LAST     = c_VW'(c_V_TOTAL - 1);
  localparam logic [c_VW-1:0]       c_V_ACT      = c_VW'(FRAME_HEIGHT);
  localparam logic [c_VW-1:0]       c_V_SYNC_BEG = c_VW'(FRAME_HEIGHT + V_FRONT);
  localparam logic [c_VW-1:0]       c_V_SYNC_END = c_VW'(FRAME_HEIGHT + V_FRONT + V_SYNC);
  localparam logic [c_SW-1:0]       c_S_LAST     = c_SW'(SCALING_FACTOR - 1);
  localparam logic [ADDR_WIDTH-1:0] c_LINE_STEP  = ADDR_WIDTH'(FRAME_WIDTH / SCALING_FACTOR);

  logic [c_HW-1:0]       r_h;
  logic [c_VW-1:0]       r_v;
  logic [c_SW-1:0]       r_xs;
  logic [c_SW-1:0]       r_ys;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_line_base;
  logic [ADDR_WIDTH-1:0] r_addr_rd;
  logic                  r_en_rd;
  logic [RD_LATENCY-1:0] r_vld_sr;
  logic [c_D-1:0]        r_de_sr;
  logic [c_D-1:0]        r_hs_sr;
  logic [c_D-1:0]        r_vs_sr;
  logic [c_D-1:0]        r_fs_sr;
  logic [DATA_WIDTH-1:0] r_pixel;

  logic w_v_act;
  logic w_active;
  logic w_h_wrap;
  logic w_v_wrap;
  logic w_hs;
  logic w_vs;
  logic w_fs;
  logic w_rd;

  assign w_v_act  = (r_v < c_V_ACT);
  assign w_active = (r_h < c_H_ACT) && w_v_act;
  assign w_h_wrap = (r_h == c_H_LAST);
  assign w_v_wrap = (r_v == c_V_LAST);
  assign w_hs     = (r_h >= c_H_SYNC_BEG && r_h < c_H_SYNC_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign w_vs     = (r_v >= c_V_SYNC_BEG && r_v < c_V_SYNC_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign w_fs     = (r_h == '0) && (r_v == '0);
  assign w_rd     = w_active & ~i_fb_rst_busy;

  // Raster counters and incremental address walk (replication without multipliers).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_h         <= '0;
      r_v         <= '0;
      r_xs        <= '0;
      r_ys        <= '0;
      r_addr      <= '0;
      r_line_base <= '0;
    end else begin
      r_h <= w_h_wrap ? '0 : r_h + 1'b1;
      if (w_h_wrap) begin
        r_v <= w_v_wrap ? '0 : r_v + 1'b1;
      end
      if (w_h_wrap && w_v_wrap) begin
        r_xs        <= '0;
        r_ys        <= '0;
        r_addr      <= '0;
        r_line_base <= '0;
      end else if (w_h_wrap && w_v_act) begin
        r_xs <= '0;
        if (r_ys == c_S_LAST) begin
          r_ys        <= '0;
          r_line_base <= r_line_base + c_LINE_STEP;
          r_addr      <= r_line_base + c_LINE_STEP;
        end else begin
          r_ys   <= r_ys + 1'b1;
          r_addr <= r_line_base;
        end
      end else if (w_active) begin
        if (r_xs == c_S_LAST) begin
          r_xs   <= '0;
          r_addr <= r_addr + 1'b1;
        end else begin
          r_xs <= r_xs + 1'b1;
        end
      end
    end
  end

  // Read request stage; the address holds while reads are suppressed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_en_rd   <= 1'b0;
      r_addr_rd <= '0;
    end else begin
      r_en_rd <= w_rd;
      if (w_rd) begin
        r_addr_rd <= r_addr;
      end
    end
  end

  // Timing delay line matched to request + memory latency + output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_de_sr  <= '0;
      r_fs_sr  <= '0;
      r_hs_sr  <= {c_D{~SYNC_ACTIVE}};
      r_vs_sr  <= {c_D{~SYNC_ACTIVE}};
      r_vld_sr <= '0;
      r_pixel  <= '0;
    end else begin
      r_de_sr     <= {r_de_sr[c_D-2:0], w_active};
      r_fs_sr     <= {r_fs_sr[c_D-2:0], w_fs};
      r_hs_sr     <= {r_hs_sr[c_D-2:0], w_hs};
      r_vs_sr     <= {r_vs_sr[c_D-2:0], w_vs};
      r_vld_sr[0] <= r_en_rd;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_vld_sr[i] <= r_vld_sr[i-1];
      end
      r_pixel <= r_vld_sr[RD_LATENCY-1] ? i_fb_dout : '0;
    end
  end

  assign o_addr_rd     = r_addr_rd;
  assign o_en_rd       = r_en_rd;
  assign o_pixel       = r_pixel;
  assign o_de          = r_de_sr[c_D-1];
  assign o_hsync       = r_hs_sr[c_D-1];
  assign o_vsync       = r_vs_sr[c_D-1];
  assign o_frame_start = r_fs_sr[c_D-1];

endmodule
`default_nettype wire

// File: tb/tb_framebuffer_scanout.sv
`default_nettype none
// tb_framebuffer_scanout: three scanout instances (SF=1/L=1, SF=2/L=1, SF=1/L=2)
// against a positional reference model with per-instance scoreboards.
module tb_framebuffer_scanout;

  localparam int W = 8, H = 4, HT = 14, VT = 7, FT = HT * VT;

  typedef struct { int cyc; bit de; bit hs; bit vs; bit fs; logic [7:0] pix; } out_t;
  typedef struct { int cyc; bit en; logic [7:0] addr; } rd_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy = 1'b0;
  int         cyc = 0;
  bit         mon_en = 1'b0;
  int         n_checks = 0;
  int         n_err = 0;

  logic [7:0] addr_w [3];
  logic [2:0] en_w, de_w, hs_w, vs_w, fs_w;
  logic [7:0] pix_w [3];
  logic [7:0] dout_w [3];
  logic [7:0] s0 [3];
  logic [7:0] s1 [3];
  logic [7:0] mem [3][256];

  out_t oq [3][$];
  rd_t  rq [3][$];

  int sf_of [3] = '{1, 2, 1};
  int d_of  [3] = '{3, 3, 4};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  framebuffer_scanout #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SYNC_ACTIVE(1'b0), .SCALING_FACTOR(1),
    .ADDR_WIDTH(8), .DATA_WIDTH(8), .RD_LATENCY(1)) u_sf1 (
    .clk(clk), .rst(rst), .i_fb_rst_busy(busy), .o_addr_rd(addr_w[0]), .o_en_rd(en_w[0]),
    .i_fb_dout(dout_w[0]), .o_pixel(pix_w[0]), .o_hsync(hs_w[0]), .o_vsync(vs_w[0]),
    .o_de(de_w[0]), .o_frame_start(fs_w[0]));

  framebuffer_scanout #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SYNC_ACTIVE(1'b0), .SCALING_FACTOR(2),
    .ADDR_WIDTH(8), .DATA_WIDTH(8), .RD_LATENCY(1)) u_sf2 (
    .clk(clk), .rst(rst), .i_fb_rst_busy(busy), .o_addr_rd(addr_w[1]), .o_en_rd(en_w[1]),
    .i_fb_dout(dout_w[1]), .o_pixel(pix_w[1]), .o_hsync(hs_w[1]), .o_vsync(vs_w[1]),
    .o_de(de_w[1]), .o_frame_start(fs_w[1]));

  framebuffer_scanout #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SYNC_ACTIVE(1'b0), .SCALING_FACTOR(1),
    .ADDR_WIDTH(8), .DATA_WIDTH(8), .RD_LATENCY(2)) u_lat2 (
    .clk(clk), .rst(rst), .i_fb_rst_busy(busy), .o_addr_rd(addr_w[2]), .o_en_rd(en_w[2]),
    .i_fb_dout(dout_w[2]), .o_pixel(pix_w[2]), .o_hsync(hs_w[2]), .o_vsync(vs_w[2]),
    .o_de(de_w[2]), .o_frame_start(fs_w[2]));

  // Framebuffer read-port model; unread cycles return junk that must be masked.
  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      s0[d] <= en_w[d] ? mem[d][addr_w[d]] : 8'($urandom);
      s1[d] <= s0[d];
    end
  end
  assign dout_w[0] = s0[0];
  assign dout_w[1] = s0[1];
  assign dout_w[2] = s1[2];

  task automatic chk(input int d, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL dut%0d %s cycle %0d: got %0h expected %0h", d, nm, cyc, act, exp);
    end
  endtask

  // Monitor: pops the expectation scheduled for this cycle, idle values otherwise.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 3; d++) begin
        out_t e;
        rd_t  r;
        while (oq[d].size() > 0 && oq[d][0].cyc < cyc) begin
          chk(d, "stale_out_token", 32'(oq[d][0].cyc), 32'(cyc));
          void'(oq[d].pop_front());
        end
        while (rq[d].size() > 0 && rq[d][0].cyc < cyc) begin
          chk(d, "stale_rd_token", 32'(rq[d][0].cyc), 32'(cyc));
          void'(rq[d].pop_front());
        end
        if (oq[d].size() > 0 && oq[d][0].cyc == cyc) e = oq[d].pop_front();
        else e = '{cyc: cyc, de: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0, pix: 8'd0};
        if (rq[d].size() > 0 && rq[d][0].cyc == cyc) r = rq[d].pop_front();
        else r = '{cyc: cyc, en: 1'b0, addr: 8'd0};
        chk(d, "de", 32'(de_w[d]), 32'(e.de));
        chk(d, "hsync", 32'(hs_w[d]), 32'(e.hs));
        chk(d, "vsync", 32'(vs_w[d]), 32'(e.vs));
        chk(d, "frame_start", 32'(fs_w[d]), 32'(e.fs));
        chk(d, "pixel", 32'(pix_w[d]), 32'(e.pix));
        chk(d, "en_rd", 32'(en_w[d]), 32'(r.en));
        chk(d, "addr_rd", 32'(addr_w[d]), 32'(r.addr));
      end
    end
  end

  initial begin
    int   pos, frame_cnt, h, v, a;
    bit   seen_rst, line_busy, did_mid_rst, do_rst, b, act;
    logic [7:0] held [3];
    pos = 0; frame_cnt = 0; seen_rst = 1'b1; line_busy = 1'b0; did_mid_rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      held[d] = 8'd0;
      for (int i = 0; i < 256; i++) mem[d][i] = 8'($urandom_range(0, 255));
    end
    for (int it = 0; it < 1500; it++) begin
      @(posedge clk);
      #1;
      if (seen_rst) mon_en = 1'b1;
      h = pos % HT;
      v = pos / HT;
      if (h == 0) line_busy = (frame_cnt >= 4) && ($urandom % 4 == 0);
      do_rst = (it < 3) || (frame_cnt == 3 && pos == 2 * HT + 4 && !did_mid_rst) ||
               (frame_cnt >= 5 && $urandom % 400 == 0);
      if (frame_cnt == 3 && pos == 2 * HT + 4) did_mid_rst = 1'b1;
      b = line_busy || (frame_cnt == 1 && v == 1) || (frame_cnt >= 4 && $urandom % 16 == 0);
      rst  = do_rst;
      busy = b;
      if (do_rst) begin
        for (int d = 0; d < 3; d++) begin
          while (oq[d].size() > 0 && oq[d][oq[d].size()-1].cyc > cyc) void'(oq[d].pop_back());
          while (rq[d].size() > 0 && rq[d][rq[d].size()-1].cyc > cyc) void'(rq[d].pop_back());
          held[d] = 8'd0;
        end
        pos = 0;
      end else begin
        act = (h < W) && (v < H);
        for (int d = 0; d < 3; d++) begin
          out_t o;
          rd_t  r;
          a = (v / sf_of[d]) * (W / sf_of[d]) + h / sf_of[d];
          if (act && !b) held[d] = 8'(a);
          o.cyc = cyc + d_of[d];
          o.de  = act;
          o.hs  = !(h >= W + 2 && h < W + 4);
          o.vs  = !(v == H + 1);
          o.fs  = (pos == 0);
          o.pix = (act && !b) ? mem[d][8'(a)] : 8'd0;
          r.cyc  = cyc + 1;
          r.en   = act && !b;
          r.addr = held[d];
          oq[d].push_back(o);
          rq[d].push_back(r);
        end
        pos = pos + 1;
        if (pos == FT) begin
          pos = 0;
          frame_cnt++;
        end
      end
    end
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
